// File: rtl/multi_timer_if.sv
// Bundled control strobes and status outputs for the multi-channel timer.
// Each per-channel field packs channel i at bit i (or at bits [i*WIDTH +: WIDTH]).
interface multi_timer_if #(
    parameter int WIDTH = 10,
    parameter int NCH   = 2
);
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       stop;
    logic [NCH-1:0]       periodic;
    logic [NCH-1:0]       hold;
    logic [NCH*WIDTH-1:0] start_time;
    logic [NCH*WIDTH-1:0] timer;
    logic [NCH-1:0]       busy;
    logic [NCH-1:0]       expired;
    logic                 irq;

    modport master (
        output start, stop, periodic, hold, start_time,
        input  timer, busy, expired, irq
    );

    modport slave (
        input  start, stop, periodic, hold, start_time,
        output timer, busy, expired, irq
    );
endinterface

// File: rtl/multi_timer.sv
// NCH independent one-shot/auto-reload down-counters; start->timer 1 cycle, expiry pulse registered.
// No backpressure: strobes are sampled every cycle and outputs are always valid.
module multi_timer #(
    parameter int WIDTH = 10,
    parameter int NCH   = 2
) (
    input  logic         clk,
    input  logic         resetn,
    multi_timer_if.slave bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q  [NCH];
    state_e           state_d  [NCH];
    logic [WIDTH-1:0] cnt_q    [NCH];
    logic [WIDTH-1:0] cnt_d    [NCH];
    logic [WIDTH-1:0] reload_q [NCH];
    logic [WIDTH-1:0] reload_d [NCH];
    logic [NCH-1:0]   mode_q;
    logic [NCH-1:0]   mode_d;
    logic [NCH-1:0]   expired_q;
    logic [NCH-1:0]   expired_d;

    logic [NCH*WIDTH-1:0] timer_flat;
    logic [NCH-1:0]       busy_flat;

    always_comb begin
        mode_d    = mode_q;
        expired_d = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            reload_d[i] = reload_q[i];

            // stop > start > hold > count
            if (bus.stop[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = S_IDLE;
            end else if (bus.start[i]) begin
                if (bus.start_time[i*WIDTH +: WIDTH] != '0) begin
                    cnt_d[i]    = bus.start_time[i*WIDTH +: WIDTH];
                    reload_d[i] = bus.start_time[i*WIDTH +: WIDTH];
                    mode_d[i]   = bus.periodic[i];
                    state_d[i]  = S_RUN;
                end else begin
                    cnt_d[i]   = '0;
                    state_d[i] = S_IDLE;
                end
            end else if (state_q[i] == S_RUN && !bus.hold[i]) begin
                if (cnt_q[i] > WIDTH'(1)) begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end else begin
                    // Terminal count: reload in the pulse cycle so the period is exactly reload.
                    expired_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        cnt_d[i] = reload_q[i];
                    end else begin
                        cnt_d[i]   = '0;
                        state_d[i] = S_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= S_IDLE;
                cnt_q[i]    <= '0;
                reload_q[i] <= '0;
            end
            mode_q    <= '0;
            expired_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                reload_q[i] <= reload_d[i];
            end
            mode_q    <= mode_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        timer_flat = '0;
        busy_flat  = '0;
        for (int i = 0; i < NCH; i++) begin
            timer_flat[i*WIDTH +: WIDTH] = cnt_q[i];
            busy_flat[i]                 = (state_q[i] == S_RUN);
        end
    end

    assign bus.timer   = timer_flat;
    assign bus.busy    = busy_flat;
    assign bus.expired = expired_q;
    assign bus.irq     = |expired_q;
endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised, multi-channel successor to the single down-counter timer used in the microstepper. It provides NCH independent down-counters, each with one-shot or periodic (auto-reload) mode, pause, and abort. Each channel emits a registered one-cycle expiry pulse, and a shared interrupt line is also provided. It sits between the step-timing logic and the phase/PWM sequencer, and generates step intervals and blanking/decay windows without software reload.

## Interface
- WIDTH, 10, counter and load-value width per channel (≥2)
- NCH, 2, number of independent channels (≥1)

- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  NCH  per-channel load/start strobe (level sampled each cycle)
- stop  in  NCH  per-channel abort strobe
- periodic  in  NCH  mode select, latched on start: 1 = auto-reload, 0 = one-shot
- hold  in  NCH  per-channel pause; counter frozen while high
- start_time  in  NCH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH]
- timer  out  NCH*WIDTH  current counter values, same packing
- busy  out  NCH  channel in RUN state
- expired  out  NCH  one-cycle registered expiry pulse per channel
- irq  out  1  OR of all expired bits (combinational from registered expired)

## Operation
- Per channel state: counter[WIDTH], reload[WIDTH], mode bit, state ∈ {IDLE, RUN}, expired bit. Channels share no state.
- Priority per channel per cycle: stop > start > hold > count.
- stop[i]: counter←0, state←IDLE, no expired pulse. This overrides a simultaneous start or expiry.
- start[i] with start_time slice V≠0: counter←V, reload←V, mode←periodic[i], state←RUN. This happens from either state, so a start in RUN restarts the channel. A pending expiry in that same cycle is discarded (no pulse).
- start[i] with V=0: counter←0, state←IDLE, no pulse.
- RUN with hold[i]=1: all channel state frozen and expired=0. busy stays 1.
- RUN with hold=0, counter>1: counter←counter−1.
- RUN with hold=0, counter==1, one-shot: counter←0, state←IDLE, expired←1.
- RUN with hold=0, counter==1, periodic: counter←reload, stays RUN, expired←1. The period is therefore exactly reload cycles.
- IDLE: counter holds its value, with no decrement and no wrap below 0.
- expired is 0 in every cycle not listed above as setting it.
- Arithmetic: unsigned. Decrement never occurs at 0, so no underflow. start_time = 2^WIDTH−1 is legal.
- periodic and start_time are only sampled on start. Changing them mid-run has no effect.

## Timing
- Reset, asynchronous assertion: timer=0, reload=0, mode=0, busy=0, expired=0, irq=0, all channels IDLE. Deassertion takes effect at the next clk edge. Reset mid-run drops any pending pulse.
- Start latency: start high at edge k gives timer=V and busy=1 after edge k.
- One-shot, no hold: start at edge k gives timer=0, busy=0 and expired=1 after edge k+V. expired is low after edge k+V+1. Total of V decrementing edges.
- Periodic: expired is high after edges k+V, k+2V, k+3V, and so on. Each pulse is one cycle wide. timer=reload is in the same cycle as the pulse.
- Each hold cycle extends the expiry by exactly one cycle.
- busy falls in the same cycle expired rises (one-shot) or after the edge where stop is sampled.
- irq has the same timing as expired, with zero added latency.

## Test plan
- Reset/one-shot: NCH=2, WIDTH=10, resetn low then high; start[0]=1 for one cycle with V=5, periodic=0 → timer0 reads 5,4,3,2,1,0. expired[0] and irq are high for exactly the 0 cycle. busy[0] falls in the same cycle. Channel 1 remains 0/idle.
- Periodic with hold: start[1] with V=3, periodic=1; hold[1] high for 2 cycles after the first expiry → pulses 3 cycles, then 5 cycles apart, then 3 apart. timer1 sequence is 3,2,1,3(pulse),… and freezes during hold.
- Priority: while channel 0 is at counter=1 in one-shot, assert start[0] with V=4 → no pulse, timer0=4. Repeat with start and stop together → timer0=0, busy=0, no pulse.
- Zero and max load: start with V=0 → busy stays 0 and there is no pulse. Start with V=1023, one-shot → expiry exactly 1023 cycles later, with no wrap.
- Async reset mid-run: channel 0 periodic at V=6; assert resetn low mid-count, between clock edges → all outputs are 0 immediately. After release, the channel stays idle until a new start.
- Independence: both channels run (V=4 periodic and V=7 one-shot) → pulses land at their own intervals. irq is high on each pulse, and both pulses land together at cycle 28 if channel 1 is restarted at the right time.
